matrix_frame_sequencer: RTL and testbench

Frame scheduler for the 8x8 LED matrix. Each frame it fetches one 64-bit glyph from the font store through a request/acknowledge handshake, then streams 32-bit LED words (start word, 64 pixel words, end words) to the strip serializer through a valid/ready handshake. It inserts a programmable idle gap between frames. It sits between the font ROM and the bit-level serializer that drives the strip clock and data pins.

---
 rtl/matrix_frame_sequencer_if.sv | 25 ++
 rtl/matrix_frame_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_frame_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_frame_sequencer_if.sv
// rtl/matrix_frame_sequencer_if.sv - font fetch and LED word handshake bundle
//
// Groups the two handshakes of the frame sequencer:
//   font_req/font_addr -> font_ack/font_data   (request/acknowledge to font store)
//   word_data/word_valid -> word_ready         (valid/ready to strip serializer)
// master: the sequencer side; slave: font store + serializer side.
interface matrix_frame_sequencer_if;
  logic        font_req;
  logic [4:0]  font_addr;
  logic        font_ack;
  logic [63:0] font_data;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output font_req, font_addr, word_data, word_valid,
    input  font_ack, font_data, word_ready
  );

  modport slave (
    input  font_req, font_addr, word_data, word_valid,
    output font_ack, font_data, word_ready
  );
endinterface

// File: rtl/matrix_frame_sequencer.sv
// rtl/matrix_frame_sequencer.sv - 8x8 LED matrix frame scheduler
//
// Per frame: fetch one 64-bit glyph, then stream a zero start word, 64 pixel
// words (on_color / off_color) and END_WORDS zero end words, then idle for
// GAP_CYCLES cycles and pulse frame_done.
//
// Parameters:
//   END_WORDS   number of zero end words (1..15)
//   GAP_CYCLES  idle cycles between last end-word transfer and frame_done (1..65535)
// Optional feature macro:
//   MATRIX_SERPENTINE_EN  even rows are streamed column-reversed
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 frames run back-to-back while high
//   glyph_sel              glyph index, latched at frame start
//   on_color, off_color    pixel words, latched at frame start
//   bus (master)           font fetch handshake and LED word stream
//   busy                   high whenever not idle
//   frame_done             one-cycle pulse on the last gap cycle
//   frame_count            completed frames, wraps at 16 bits
module matrix_frame_sequencer #(
  parameter int END_WORDS  = 2,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [4:0]                      glyph_sel,
  input  logic [31:0]                     on_color,
  input  logic [31:0]                     off_color,
  matrix_frame_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            frame_done,
  output logic [15:0]                     frame_count
);

  localparam logic [3:0]  END_LAST = 4'(END_WORDS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_PIXEL,
    S_END,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] glyph_q, glyph_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] on_q, on_d;
  logic [31:0] off_q, off_d;
  logic [5:0]  pidx_q, pidx_d;
  logic [3:0]  end_q, end_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] count_q, count_d;

  logic        font_req_q, font_req_d;
  logic [31:0] word_data_q, word_data_d;
  logic        word_valid_q, word_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        xfer;
  logic [5:0]  zz;
  logic        lit;

  assign xfer = word_valid_q & bus.word_ready;

  // Next-state logic; outputs are computed from the next state so that every
  // output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    glyph_d    = glyph_q;
    sel_d      = sel_q;
    on_d       = on_q;
    off_d      = off_q;
    pidx_d     = pidx_q;
    end_d      = end_q;
    gap_d      = gap_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FETCH;
          sel_d   = glyph_sel;
          on_d    = on_color;
          off_d   = off_color;
        end
      end
      S_FETCH: begin
        if (bus.font_ack) begin
          state_d = S_START;
          glyph_d = bus.font_data;
        end
      end
      S_START: begin
        if (xfer) begin
          state_d = S_PIXEL;
          pidx_d  = 6'd0;
        end
      end
      S_PIXEL: begin
        if (xfer) begin
          pidx_d = pidx_q + 6'd1;
          if (pidx_q == 6'd63) begin
            state_d = S_END;
            end_d   = 4'd0;
          end
        end
      end
      S_END: begin
        if (xfer) begin
          if (end_q == END_LAST) begin
            state_d = S_GAP;
            gap_d   = 16'd0;
          end else begin
            end_d = end_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (enable) begin
            state_d = S_FETCH;
            sel_d   = glyph_sel;
            on_d    = on_color;
            off_d   = off_color;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The cycle about to be entered is the last gap cycle.
    done_d = (state_d == S_GAP) && (gap_d == GAP_LAST);
    if (done_d) begin
      count_d = count_q + 16'd1;
    end

    font_req_d   = (state_d == S_FETCH);
    word_valid_d = (state_d == S_START) || (state_d == S_PIXEL) || (state_d == S_END);
    busy_d       = (state_d != S_IDLE);
  end

`ifdef MATRIX_SERPENTINE_EN
  // Even rows (pidx[3]==0) are wired right-to-left: zz = 8r + (7 - c).
  assign zz = pidx_d[3] ? pidx_d : {pidx_d[5:3], ~pidx_d[2:0]};
`else
  assign zz = pidx_d;
`endif

  // Bit 63 of the glyph is pixel 0.
  assign lit = glyph_d[6'd63 - zz];

  always_comb begin
    word_data_d = 32'd0;
    if (state_d == S_PIXEL) begin
      word_data_d = lit ? on_d : off_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      glyph_q      <= 64'd0;
      sel_q        <= 5'd0;
      on_q         <= 32'd0;
      off_q        <= 32'd0;
      pidx_q       <= 6'd0;
      end_q        <= 4'd0;
      gap_q        <= 16'd0;
      count_q      <= 16'd0;
      font_req_q   <= 1'b0;
      word_data_q  <= 32'd0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      glyph_q      <= glyph_d;
      sel_q        <= sel_d;
      on_q         <= on_d;
      off_q        <= off_d;
      pidx_q       <= pidx_d;
      end_q        <= end_d;
      gap_q        <= gap_d;
      count_q      <= count_d;
      font_req_q   <= font_req_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.font_req   = font_req_q;
  assign bus.font_addr  = sel_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_valid = word_valid_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// tb/tb_matrix_frame_sequencer.sv - self-checking bench for matrix_frame_sequencer
module tb_matrix_frame_sequencer;
  localparam int END_W = 2;
  localparam int GAP   = 4;
  localparam int NW    = 65 + END_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  glyph_sel = 5'd0;
  logic [31:0] on_color = 32'd0;
  logic [31:0] off_color = 32'd0;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  matrix_frame_sequencer_if bus ();

  matrix_frame_sequencer #(.END_WORDS(END_W), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .glyph_sel   (glyph_sel),
    .on_color    (on_color),
    .off_color   (off_color),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_words [NW];
  logic [15:0] exp_count = 16'd0;
  logic [4:0]  nxt_gsel = 5'd0;
  logic [31:0] nxt_on = 32'd0;
  logic [31:0] nxt_off = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected word stream of one frame, straight from the pixel mapping rules.
  function automatic void build(input logic [63:0] fd, input logic [31:0] onc, input logic [31:0] offc);
    int row, col, zz;
    exp_words[0] = 32'd0;
    for (int p = 0; p < 64; p++) begin
      row = p / 8;
      col = p % 8;
`ifdef MATRIX_SERPENTINE_EN
      zz = (row % 2 == 0) ? row * 8 + 7 - col : p;
`else
      zz = p + 0 * (row + col);
`endif
      exp_words[1 + p] = fd[63 - zz] ? onc : offc;
    end
    for (int e = 0; e < END_W; e++) exp_words[65 + e] = 32'd0;
  endfunction

  // Runs one frame starting at a negedge with the DUT idle (or already fetching
  // when the previous frame kept enable high). Returns at the frame_done negedge.
  task automatic run_frame(input logic [4:0] gsel, input logic [31:0] onc, input logic [31:0] offc,
                           input logic [63:0] fdata, input int ack_delay, input bit rand_ready,
                           input int drop_at, input bit keep_en, input bit from_idle);
    int idx, cycles, gapc, reqc;
    bit acked, ack_pend, done;
    logic [15:0] cnt0;
    build(fdata, onc, offc);
    idx = 0; cycles = 0; gapc = 0; reqc = 0;
    acked = 0; ack_pend = 0; done = 0;
    cnt0 = exp_count;
    if (from_idle) begin
      enable = 1'b1;
      glyph_sel = gsel;
      on_color = onc;
      off_color = offc;
    end
    bus.font_ack = 1'b1;              // ignored outside FETCH
    bus.font_data = ~fdata;
    bus.word_ready = 1'b1;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (ack_pend) begin acked = 1; ack_pend = 0; end
      if (cycles > 3000) begin
        vectors++; errors++;
        $error("FAIL frame_timeout: observed %0d cycles expected frame end", cycles);
        break;
      end
      if (cycles == 1 && from_idle) check("req_latency", bus.font_req, 1'b1);
      check("busy", busy, 1'b1);
      if (bus.font_req) begin
        reqc++;
        check("font_addr", bus.font_addr, gsel);
      end
      if (acked) check("req_drop", bus.font_req, 1'b0);
      if (!acked) check("valid_before_ack", bus.word_valid, 1'b0);
      else if (idx < NW) check("word_valid", bus.word_valid, 1'b1);
      if (idx == NW) begin
        gapc++;
        check("gap_valid", bus.word_valid, 1'b0);
      end
      if (bus.word_valid && idx < NW) check($sformatf("word_%0d", idx), bus.word_data, exp_words[idx]);
      check("frame_done", frame_done, (gapc == GAP));
      check("frame_count", frame_count, (gapc == GAP) ? cnt0 + 16'd1 : cnt0);
      if (gapc == GAP) begin
        exp_count = cnt0 + 16'd1;
        done = 1;
      end
      // drive the next cycle
      if (bus.font_req && !acked && !ack_pend) begin
        if (reqc >= ack_delay) begin
          bus.font_ack = 1'b1; bus.font_data = fdata; ack_pend = 1;
        end else begin
          bus.font_ack = 1'b0; bus.font_data = {$urandom, $urandom};
        end
      end else if (acked && !done) begin
        bus.font_ack = 1'($urandom_range(0, 1));
        bus.font_data = {$urandom, $urandom};
      end else begin
        bus.font_ack = 1'b0;
      end
      bus.word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.word_valid && bus.word_ready && idx < NW) idx++;
      if (done && keep_en) begin
        glyph_sel = nxt_gsel; on_color = nxt_on; off_color = nxt_off;
      end else if (cycles >= 1) begin
        glyph_sel = 5'($urandom); on_color = $urandom; off_color = $urandom;
      end
      if (!keep_en && idx >= drop_at) enable = 1'b0;
    end
    check("transfers", idx, NW);
    check("req_cycles", reqc, ack_delay);
    @(negedge clk);
    if (keep_en) begin
      check("b2b_req", bus.font_req, 1'b1);
      check("b2b_addr", bus.font_addr, nxt_gsel);
    end else begin
      check("idle_busy", busy, 1'b0);
      check("idle_req", bus.font_req, 1'b0);
    end
    check("done_pulse", frame_done, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, bus.font_req, 1'b0);
    check({tag, "_addr"}, bus.font_addr, 5'd0);
    check({tag, "_data"}, bus.word_data, 32'd0);
    check({tag, "_valid"}, bus.word_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_count"}, frame_count, 16'd0);
  endtask

  initial begin
    int n;
    bus.font_ack = 1'b0;
    bus.font_data = 64'd0;
    bus.word_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 1'b0);

    // basic frame
    run_frame(5'd0, 32'hF00F0000, 32'hF0000000, 64'h0000780C7CCC7600, 1, 0, 0, 0, 1);
    // backpressure
    run_frame(5'($urandom), $urandom, $urandom, {$urandom, $urandom}, 2, 1, 0, 0, 1);
    // fetch stall
    run_frame(5'd17, 32'h00FF00FF, 32'h11000011, {$urandom, $urandom}, 20, 0, 0, 0, 1);
    // single lit pixel (serpentine mapping visible when enabled)
    run_frame(5'd3, 32'hAAAA5555, 32'h0F0F0F0F, 64'h8000000000000000, 1, 0, 0, 0, 1);
    // enable held through pixel 30
    run_frame(5'd9, 32'h12345678, 32'h87654321, {$urandom, $urandom}, 3, 0, 31, 0, 1);
    // random frames
    for (int f = 0; f < 3; f++)
      run_frame(5'($urandom), $urandom, $urandom, {$urandom, $urandom},
                int'($urandom_range(1, 5)), 1, int'($urandom_range(0, NW)), 0, 1);
    // back-to-back: enable stays high across the gap
    nxt_gsel = 5'd21; nxt_on = 32'hDEADBEEF; nxt_off = 32'h0BADF00D;
    run_frame(5'd30, $urandom, $urandom, {$urandom, $urandom}, 1, 1, 0, 1, 1);

    // second frame is fetching; stream into PIXEL then reset asynchronously
    enable = 1'b0;
    bus.font_ack = 1'b1;
    bus.font_data = {$urandom, $urandom};
    bus.word_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 12; k++) begin
      @(negedge clk);
      if (bus.word_valid) n++;
    end
    check("pre_reset_valid", bus.word_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.font_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("released_busy", busy, 1'b0);
      check("released_valid", bus.word_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
